// File: rtl/pll_lock_sequencer.sv
// PLL bring-up and supervision sequencer.
// Holds the PLL in reset for a minimum width, then waits for a synchronized lock
// with a bounded timeout and retry count. Lock must be stable before the system
// reset is released. Loss of lock in RUN re-runs the sequence.
// Outputs are registered from the next state, so they change on the same edge
// as the state register.
module pll_lock_sequencer #(
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned LOCK_TIMEOUT = 65536,
  parameter int unsigned LOCK_STABLE  = 256,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_cnt,
  output logic [7:0] loss_cnt
);

  localparam int unsigned TmrMaxAb = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned TmrMax   = (TmrMaxAb > LOCK_STABLE) ? TmrMaxAb : LOCK_STABLE;
  // The timer only ever has to hold TmrMax-1.
  localparam int unsigned TmrW     = (TmrMax > 1) ? $clog2(TmrMax) : 1;

  localparam logic [TmrW-1:0] RstLast    = TmrW'(RST_CYCLES - 1);
  localparam logic [TmrW-1:0] TimeoutLast = TmrW'(LOCK_TIMEOUT - 1);
  localparam logic [TmrW-1:0] StableLast = TmrW'(LOCK_STABLE - 1);
  localparam logic [3:0]      MaxRetry   = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    StPllRst,
    StWaitLock,
    StStable,
    StRun,
    StFault
  } state_e;

  state_e          state_q, state_d;
  logic [TmrW-1:0] tmr_q, tmr_d;
  logic [1:0]      sync_q;
  logic            lk_s;
  logic [3:0]      retry_q, retry_d;
  logic [7:0]      loss_q, loss_d;
  logic            pll_rst_q, pll_rst_d;
  logic            sys_rst_q, sys_rst_d;
  logic            ready_q, ready_d;
  logic            fault_q, fault_d;

  assign lk_s = sync_q[1];

  // Two-flop synchronizer for the asynchronous PLL lock indication.
  always_ff @(posedge refclk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], pll_locked};
    end
  end

  // State, timer, counters and registered outputs.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q   <= StPllRst;
      tmr_q     <= '0;
      retry_q   <= '0;
      loss_q    <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      retry_q   <= retry_d;
      loss_q    <= loss_d;
      pll_rst_q <= pll_rst_d;
      sys_rst_q <= sys_rst_d;
      ready_q   <= ready_d;
      fault_q   <= fault_d;
    end
  end

  // Next-state, timer and counter logic; restart overrides every state.
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    loss_d  = loss_q;

    if (restart) begin
      state_d = StPllRst;
      retry_d = '0;
    end else begin
      case (state_q)
        StPllRst: begin
          if (tmr_q == RstLast) state_d = StWaitLock;
        end
        StWaitLock: begin
          if (lk_s) begin
            state_d = StStable;
          end else if (tmr_q == TimeoutLast) begin
            if (retry_q == MaxRetry) begin
              state_d = StFault;
            end else begin
              retry_d = retry_q + 4'd1;
              state_d = StPllRst;
            end
          end
        end
        StStable: begin
          // A dropout sends us back to waiting without spending a retry.
          if (!lk_s) begin
            state_d = StWaitLock;
          end else if (tmr_q == StableLast) begin
            state_d = StRun;
          end
        end
        StRun: begin
          if (!lk_s) begin
            if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
            retry_d = '0;
            state_d = StPllRst;
          end
        end
        StFault: begin
          state_d = StFault;
        end
        default: begin
          state_d = StPllRst;
        end
      endcase
    end

    // Timer clears on any state change or restart; it idles in untimed states.
    if (restart || (state_d != state_q)) begin
      tmr_d = '0;
    end else if ((state_q == StRun) || (state_q == StFault)) begin
      tmr_d = tmr_q;
    end else begin
      tmr_d = tmr_q + TmrW'(1);
    end
  end

  // Output decode from the next state so outputs align with the state register.
  always_comb begin
    pll_rst_d = (state_d == StPllRst) || (state_d == StFault);
    sys_rst_d = (state_d != StRun);
    ready_d   = (state_d == StRun);
    fault_d   = (state_d == StFault);
  end

  assign pll_rst   = pll_rst_q;
  assign sys_rst   = sys_rst_q;
  assign ready     = ready_q;
  assign fault     = fault_q;
  assign retry_cnt = retry_q;
  assign loss_cnt  = loss_q;

endmodule
